// File: rtl/regfile_pkg.sv
// Shared constants and types for the architectural register file write side.
package regfile_pkg;

  localparam int        NUM_REGS   = 32;
  localparam int        REG_ADDR_W = 5;
  localparam logic [4:0] ZERO_REG  = 5'd31;

  typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage : regfile_pkg

// File: rtl/decoder5x32.sv
// 5-to-32 one-hot write-enable decoder; output 31 (XZR) is never asserted.
module decoder5x32
  import regfile_pkg::*;
(
  input  logic [4:0]  in,
  input  logic        en,
  output logic [31:0] out
);

  always_comb begin
    // NOTE: default the whole output first so no path through this block leaves it unassigned (no latch).
    out = '0;
    if (en) begin
      out[in] = 1'b1;
    end
    out[ZERO_REG] = 1'b0;
  end

endmodule : decoder5x32

// File: rtl/regfile_writer.sv
// Write side of the 32-entry register file: decode, one-cycle staging, commit.
// Optional macro REGFILE_WRITE_BYPASS_EN forwards the staged write onto reg_out.
module regfile_writer
  import regfile_pkg::*;
#(
  parameter int SIZE  = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  reg_addr_t        wr_addr,
  input  logic [SIZE-1:0]  wr_data,
  input  logic             stall,
  output logic             wr_ready,
  output logic [SIZE-1:0]  reg_out [NUM_REGS],
  output logic             pending,
  output reg_addr_t        pending_addr,
  output logic [CNT_W-1:0] commit_count
);

  logic                accept;
  logic                commit;
  logic [NUM_REGS-1:0] dec_onehot;
  logic [NUM_REGS-1:0] s1_onehot;
  logic [SIZE-1:0]     s1_data;
  // X31 has no storage; only entries 0..30 exist.
  logic [SIZE-1:0]     regs [NUM_REGS-1];

  assign wr_ready = !(pending && stall);
  assign accept   = wr_en && wr_ready;
  assign commit   = pending && !stall;

  // Gating with accept keeps an undriven wr_addr from reaching the staging register.
  decoder5x32 u_decoder (
    .in  (wr_addr),
    .en  (accept),
    .out (dec_onehot)
  );

  // Staging register S1: loads on accept, holds under stall, empties otherwise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pending      <= 1'b0;
      pending_addr <= '0;
      s1_data      <= '0;
      s1_onehot    <= '0;
    end else if (accept) begin
      // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
      pending      <= 1'b1;
      pending_addr <= wr_addr;
      s1_data      <= wr_data;
      s1_onehot    <= dec_onehot;
    end else if (!stall) begin
      pending      <= 1'b0;
    end
  end

  // Register storage; a staged X31 write has an all-zero one-hot and touches nothing.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the architectural state must read zero after reset, so this array is reset explicitly.
      for (int k = 0; k < NUM_REGS - 1; k++) begin
        regs[k] <= '0;
      end
    end else if (commit) begin
      for (int k = 0; k < NUM_REGS - 1; k++) begin
        if (s1_onehot[k]) begin
          regs[k] <= s1_data;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      commit_count <= '0;
    end else if (commit && (|s1_onehot)) begin
      commit_count <= commit_count + 1'b1;
    end
  end

  always_comb begin
    for (int k = 0; k < NUM_REGS - 1; k++) begin
      reg_out[k] = regs[k];
`ifdef REGFILE_WRITE_BYPASS_EN
      if (pending && (pending_addr != ZERO_REG) && (pending_addr == reg_addr_t'(k))) begin
        reg_out[k] = s1_data;
      end
`else
`endif
    end
    reg_out[NUM_REGS-1] = '0;
  end

endmodule : regfile_writer

// File: tb/tb_regfile_writer.sv
// Self-checking bench for regfile_writer: directed scenarios plus random traffic
// compared every cycle against a behavioural register-file model.
module tb_regfile_writer;

  localparam int SIZE  = 64;
  localparam int CNT_W = 4;
  localparam int NREG  = 32;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             wr_en = 1'b0;
  logic [4:0]       wr_addr = '0;
  logic [SIZE-1:0]  wr_data = '0;
  logic             stall = 1'b0;
  logic             wr_ready;
  logic [SIZE-1:0]  reg_out [NREG];
  logic             pending;
  logic [4:0]       pending_addr;
  logic [CNT_W-1:0] commit_count;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  // Behavioural model: plain array of register values, one staged entry, integer counter.
  logic [SIZE-1:0] m_regs [NREG];
  bit              m_pend;
  int              m_addr;
  logic [SIZE-1:0] m_data;
  int              m_count;

  regfile_writer #(.SIZE(SIZE), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .stall        (stall),
    .wr_ready     (wr_ready),
    .reg_out      (reg_out),
    .pending      (pending),
    .pending_addr (pending_addr),
    .commit_count (commit_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model advance: a staged write lands when not stalled; a new request enters when S1 is free or draining.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NREG; k++) m_regs[k] <= '0;
      m_pend  <= 1'b0;
      m_addr  <= 0;
      m_data  <= '0;
      m_count <= 0;
    end else begin
      if (m_pend && !stall && m_addr != 31) begin
        m_regs[m_addr] <= m_data;
        m_count        <= (m_count + 1) % (1 << CNT_W);
      end
      if (wr_en && !(m_pend && stall)) begin
        m_pend <= 1'b1;
        m_addr <= int'(wr_addr);
        m_data <= wr_data;
      end else if (!stall) begin
        m_pend <= 1'b0;
      end
    end
  end

  function automatic logic [SIZE-1:0] exp_reg(input int k);
    logic [SIZE-1:0] v;
    v = (k == 31) ? '0 : m_regs[k];
`ifdef REGFILE_WRITE_BYPASS_EN
    if (m_pend && m_addr != 31 && m_addr == k) v = m_data;
`endif
    return v;
  endfunction

  // Single compare process: all outputs checked against the model on every falling edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      check("wr_ready", 64'(wr_ready), 64'(!(m_pend && stall)));
      check("pending", 64'(pending), 64'(m_pend));
      if (m_pend) check("pending_addr", 64'(pending_addr), 64'(m_addr));
      check("commit_count", 64'(commit_count), 64'(m_count));
      for (int k = 0; k < NREG; k++) begin
        check($sformatf("reg_out[%0d]", k), reg_out[k], exp_reg(k));
      end
    end
  end

  task automatic drive(input logic en, input logic [4:0] addr, input logic [SIZE-1:0] data,
                       input logic st);
    wr_en   = en;
    wr_addr = addr;
    wr_data = data;
    stall   = st;
    @(posedge clk);
    #1;
  endtask

  initial begin
    // 1: reset held with a live request presented
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 64'hABCD;
    repeat (2) @(posedge clk);
    #1;
    cmp_en = 1'b1;
    repeat (3) drive(1'b1, 5'd3, 64'hABCD, 1'b0);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_count", 64'(commit_count), 64'd0);
    check("rst_reg3", reg_out[3], 64'd0);
    reset_n = 1'b1;
    drive(1'b0, 5'd0, '0, 1'b0);

    // 2: single write, one-cycle staging
    drive(1'b1, 5'd5, 64'hDEAD_BEEF, 1'b0);
    check("single_pending", 64'(pending), 64'd1);
    check("single_paddr", 64'(pending_addr), 64'd5);
    drive(1'b0, 5'd0, '0, 1'b0);
    check("single_reg5", reg_out[5], 64'hDEAD_BEEF);
    check("single_count", 64'(commit_count), 64'd1);
    check("single_reg4", reg_out[4], 64'd0);

    // 3: back-to-back writes
    drive(1'b1, 5'd1, 64'h11, 1'b0);
    drive(1'b1, 5'd2, 64'h22, 1'b0);
    drive(1'b1, 5'd3, 64'h33, 1'b0);
    drive(1'b0, 5'd0, '0, 1'b0);
    check("b2b_reg1", reg_out[1], 64'h11);
    check("b2b_reg2", reg_out[2], 64'h22);
    check("b2b_reg3", reg_out[3], 64'h33);
    check("b2b_count", 64'(commit_count), 64'd4);

    // 4: stall with a staged write; new requests refused
    drive(1'b1, 5'd7, 64'h77, 1'b0);
    repeat (3) drive(1'b1, 5'd8, 64'h88, 1'b1);
    check("stall_ready", 64'(wr_ready), 64'd0);
`ifdef REGFILE_WRITE_BYPASS_EN
    check("stall_reg7", reg_out[7], 64'h77);
`else
    check("stall_reg7", reg_out[7], 64'd0);
`endif
    drive(1'b0, 5'd0, '0, 1'b0);
    check("unstall_reg7", reg_out[7], 64'h77);
    check("unstall_reg8", reg_out[8], 64'd0);
    check("unstall_count", 64'(commit_count), 64'd5);

    // 5: X31 write commits nothing; then 11 commits wrap the 4-bit counter to 0
    drive(1'b1, 5'd31, 64'hFF, 1'b0);
    check("x31_pending", 64'(pending), 64'd1);
    drive(1'b0, 5'd0, '0, 1'b0);
    check("x31_reg", reg_out[31], 64'd0);
    check("x31_count", 64'(commit_count), 64'd5);
    for (int i = 0; i < 11; i++) drive(1'b1, 5'(i), 64'(i + 64'h100), 1'b0);
    drive(1'b0, 5'd0, '0, 1'b0);
    check("wrap_count", 64'(commit_count), 64'd0);
    check("wrap_reg10", reg_out[10], 64'h10A);

    // 6: reset pulse between accept and commit drops the staged write
    drive(1'b1, 5'd9, 64'h99, 1'b0);
    wr_en = 1'b0;
    #1 reset_n = 1'b0;
    #2 reset_n = 1'b1;
    drive(1'b0, 5'd0, '0, 1'b0);
    check("midrst_reg9", reg_out[9], 64'd0);
    check("midrst_pending", 64'(pending), 64'd0);
    check("midrst_count", 64'(commit_count), 64'd0);

    // Random traffic; idle cycles sometimes carry an undriven address
    for (int i = 0; i < 500; i++) begin
      logic            en, st;
      logic [4:0]      a;
      logic [SIZE-1:0] d;
      en = ($urandom_range(0, 3) != 0);
      st = ($urandom_range(0, 3) == 0);
      a  = 5'($urandom_range(0, 31));
      d  = {$urandom, $urandom};
      if (!en && $urandom_range(0, 1) == 1) a = 'x;
      drive(en, a, d, st);
    end
    drive(1'b0, 5'd0, '0, 1'b0);
    drive(1'b0, 5'd0, '0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_regfile_writer
